// File: rtl/spi_disp_arbiter_if.sv
// spi_disp_arbiter_if: requester handshake bus plus the SPI shifter link and
// the link-status outputs. The arbiter attaches through the slave modport;
// the requesters/shifter side (or a testbench) uses the master modport.
interface spi_disp_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_dc;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        spi_start;
  logic [7:0]  spi_data;
  logic        spi_dc;
  logic        spi_done;
  logic        cs;
  logic        busy;

  modport master (
    output req_valid, req_data, req_dc, req_last, spi_done,
    input  req_ready, grant, spi_start, spi_data, spi_dc, cs, busy
  );

  modport slave (
    input  req_valid, req_data, req_dc, req_last, spi_done,
    output req_ready, grant, spi_start, spi_data, spi_dc, cs, busy
  );
endinterface

// File: rtl/spi_disp_arbiter.sv
// spi_disp_arbiter: shares one SPI byte shifter among four requesters.
// The link is granted per burst; the active-low chip select stays low for the
// whole burst, with CS_SETUP cycles before the first byte and at least
// max(CS_IDLE,1) high cycles after the burst.
// Optional feature macro: SPI_ARB_FIXED_PRIO_EN -- when defined the lowest
// valid index always wins and no round-robin pointer exists; otherwise the
// search starts at the requester after the previous owner.
module spi_disp_arbiter #(
  parameter int unsigned CS_SETUP = 32'd2,
  parameter int unsigned CS_IDLE  = 32'd2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  spi_disp_arbiter_if.slave io_bus
);

  localparam int unsigned      IDLE_CYC   = (CS_IDLE == 32'd0) ? 32'd1 : CS_IDLE;
  localparam int unsigned      CNT_W      = 16;
  // SETUP_LAST is only consulted when CS_SETUP is non-zero
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 32'd1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 32'd1);
  localparam logic             SKIP_SETUP = (CS_SETUP == 32'd0);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_owner;
  logic [1:0]       w_owner_nxt;
  logic [3:0]       r_grant;
  logic             r_cs;
  logic             r_start;
  logic [7:0]       r_data;
  logic             r_dc;
  logic             r_last;
  logic [3:0]       w_ready;
  logic             w_accept;
  logic [1:0]       w_base;
  logic [2:0]       w_pick;

  // Search order base, ptr, ptr+1, ... mod 4; returns {found, index}
  function automatic logic [2:0] rr_pick(input logic [3:0] vld, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (vld[idx]) res = {1'b1, idx};
      else          res = res;
    end
    return res;
  endfunction

`ifdef SPI_ARB_FIXED_PRIO_EN
  assign w_base = 2'b00;
`else
  logic [1:0] r_ptr;

  // Round-robin pointer moves past the owner when its burst releases the link
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= 2'b00;
    end else if ((w_state_nxt == ST_RELEASE) && (r_state != ST_RELEASE)) begin
      r_ptr <= r_owner + 2'd1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign w_base = r_ptr;
`endif

  assign w_pick = rr_pick(io_bus.req_valid, w_base);

  // Next-state decode and the combinational ready of the owner in LOAD
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 4'b0000;
    w_accept    = 1'b0;
    w_owner_nxt = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (w_pick[2]) begin
          w_owner_nxt = w_pick[1:0];
          w_state_nxt = SKIP_SETUP ? ST_LOAD : ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (r_cnt == SETUP_LAST) w_state_nxt = ST_LOAD;
        else                     w_state_nxt = ST_SETUP;
      end
      ST_LOAD: begin
        // A stalled owner keeps the link locked; nobody else is granted
        w_ready[r_owner] = io_bus.req_valid[r_owner];
        if (io_bus.req_valid[r_owner]) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_WAIT: begin
        if (io_bus.spi_done) w_state_nxt = r_last ? ST_RELEASE : ST_LOAD;
        else                 w_state_nxt = ST_WAIT;
      end
      ST_RELEASE: begin
        if (r_cnt == IDLE_LAST) w_state_nxt = ST_IDLE;
        else                    w_state_nxt = ST_RELEASE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and gap counter, which restarts on every state change
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= {CNT_W{1'b0}};
      else                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered owner, byte capture, start pulse, grant and chip select
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_owner <= 2'b00;
      r_start <= 1'b0;
      r_data  <= 8'h00;
      r_dc    <= 1'b0;
      r_last  <= 1'b0;
      r_grant <= 4'b0000;
      r_cs    <= 1'b1;
    end else begin
      r_owner <= w_owner_nxt;
      r_start <= w_accept;
      if (w_accept) begin
        r_data <= io_bus.req_data[{r_owner, 3'b000} +: 8];
        r_dc   <= io_bus.req_dc[r_owner];
        r_last <= io_bus.req_last[r_owner];
      end else begin
        r_data <= r_data;
        r_dc   <= r_dc;
        r_last <= r_last;
      end
      case (w_state_nxt)
        ST_SETUP, ST_LOAD, ST_WAIT: begin
          r_cs    <= 1'b0;
          r_grant <= 4'b0001 << w_owner_nxt;
        end
        default: begin
          r_cs    <= 1'b1;
          r_grant <= 4'b0000;
        end
      endcase
    end
  end

  assign io_bus.req_ready = w_ready;
  assign io_bus.grant     = r_grant;
  assign io_bus.spi_start = r_start;
  assign io_bus.spi_data  = r_data;
  assign io_bus.spi_dc    = r_dc;
  assign io_bus.cs        = r_cs;
  assign io_bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_disp_arbiter.sv
// tb_spi_disp_arbiter: randomized and directed stimulus for spi_disp_arbiter.
// Requesters are byte queues; the shifter answers each start with a done pulse
// after a fixed or random delay. A transaction-level reference model predicts
// grant, cs, busy, req_ready, spi_start and the forwarded byte every cycle.
module tb_spi_disp_arbiter;
  localparam int CS_SETUP = 2;
  localparam int CS_IDLE  = 2;
  localparam int IDLE_N   = (CS_IDLE == 0) ? 1 : CS_IDLE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // 10-unit clock
  always #5 clk = ~clk;

  spi_disp_arbiter_if bus();

  spi_disp_arbiter #(.CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // requester queues: {last, dc, data}
  logic [9:0] q [4][$];
  logic [3:0] stall = 4'b0000;
  logic       rst_nxt = 1'b1;
  int         done_at = -1;
  int         dly_fixed = 0;

  // previous-cycle facts used by the model
  logic [3:0] vld_prev = 4'b0000;
  logic       done_prev = 1'b0;
  logic       rst_prev = 1'b1;
  logic       acc_prev = 1'b0;
  int         acc_idx = 0;
  logic [3:0] grant_prev = 4'b0000;
  logic       cs_prev = 1'b1;

  // reference model
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_phase = 0;   // 0 no burst, 2 waiting to hand a byte, 3 byte in flight
  int         m_load_at = 0;
  int         m_idle_ok = 0;
  logic [9:0] m_byte = 10'd0;

  // observation logs
  int st_cyc[$];
  int st_byte[$];
  int dn_cyc[$];
  int gr_cyc[$];
  int gr_val[$];
  int rd_cyc[$];
  int cs_up[$];
  int cs_dn[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    int p;
    p = ptr;
`ifdef SPI_ARB_FIXED_PRIO_EN
    p = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic int qget(input int qq[$], input int i);
    if (i < qq.size()) return qq[i];
    return -1;
  endfunction

  task automatic clear_logs();
    st_cyc.delete(); st_byte.delete(); dn_cyc.delete(); gr_cyc.delete();
    gr_val.delete(); rd_cyc.delete(); cs_up.delete(); cs_dn.delete();
  endtask

  task automatic push_burst(input int r, input int len);
    for (int j = 0; j < len; j++)
      q[r].push_back({1'(j == len - 1), 1'($urandom), 8'($urandom)});
  endtask

  // One clock: drive inputs after the edge, then check outputs on the falling edge
  task automatic step();
    logic [3:0] v, eg, er;
    logic       es, eb, acc;
    logic [9:0] e;
    int         w;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_prev && (q[acc_idx].size() > 0)) void'(q[acc_idx].pop_front());
    rst = rst_nxt;
    bus.spi_done = (cyc == done_at);
    for (int i = 0; i < 4; i++) begin
      v[i] = (q[i].size() > 0) && !stall[i];
      if (q[i].size() > 0) e = q[i][0];
      else                 e = 10'($urandom);
      bus.req_data[8*i +: 8] = e[7:0];
      bus.req_dc[i]          = e[8];
      bus.req_last[i]        = e[9];
    end
    bus.req_valid = v;
    @(negedge clk);

    es = 1'b0;
    if (rst_prev) begin
      m_owner = -1; m_ptr = 0; m_phase = 0; m_idle_ok = cyc + 1;
    end else begin
      es = acc_prev;
      if (done_prev && (m_phase == 3)) begin
        if (m_byte[9]) begin
          m_ptr = (m_owner + 1) % 4; m_owner = -1; m_phase = 0;
          m_idle_ok = cyc + 1 + IDLE_N;
        end else begin
          m_phase = 2; m_load_at = cyc;
        end
      end
      if (acc_prev) m_phase = 3;
      if ((m_owner < 0) && (cyc >= m_idle_ok) && (vld_prev != 4'b0000)) begin
        w = pick(vld_prev, m_ptr);
        m_owner = w; m_phase = 2; m_load_at = cyc + CS_SETUP;
      end
    end
    eg  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    eb  = !((m_owner < 0) && (cyc >= m_idle_ok - 1));
    er  = ((m_phase == 2) && (cyc >= m_load_at)) ? (v & eg) : 4'b0000;
    acc = (er != 4'b0000) && !rst;

    check_eq("grant", 32'(bus.grant), 32'(eg));
    check_eq("cs", 32'(bus.cs), 32'(eg == 4'b0000));
    check_eq("busy", 32'(bus.busy), 32'(eb));
    check_eq("req_ready", 32'(bus.req_ready), 32'(er));
    check_eq("spi_start", 32'(bus.spi_start), 32'(es));
    if (m_phase == 3) check_eq("spi_byte", 32'({bus.spi_dc, bus.spi_data}), 32'(m_byte[8:0]));
    if (acc) begin
      acc_idx = m_owner;
      m_byte  = q[m_owner][0];
    end

    if (bus.spi_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_byte.push_back(int'({bus.spi_dc, bus.spi_data}));
      done_at = cyc + ((dly_fixed > 0) ? dly_fixed : int'($urandom_range(1, 6)));
    end
    if (bus.spi_done) dn_cyc.push_back(cyc);
    if (bus.req_ready != 4'b0000) rd_cyc.push_back(cyc);
    if ((bus.grant != 4'b0000) && (grant_prev == 4'b0000)) begin
      gr_cyc.push_back(cyc); gr_val.push_back(int'(bus.grant));
    end
    if (bus.cs && !cs_prev) cs_up.push_back(cyc);
    if (!bus.cs && cs_prev) cs_dn.push_back(cyc);
    if (rst) done_at = -1;
    grant_prev = bus.grant; cs_prev = bus.cs;
    vld_prev = v; done_prev = bus.spi_done; rst_prev = rst; acc_prev = acc;
  endtask

  task automatic run_until_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      step();
      if ((q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) &&
          (m_owner < 0) && (cyc >= m_idle_ok)) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("drain", 32'(ok), 32'd1);
  endtask

  initial begin
    int t0, tc, tb, n0;
    bus.req_valid = 4'b0000; bus.req_data = 32'd0; bus.req_dc = 4'b0000;
    bus.req_last = 4'b0000; bus.spi_done = 1'b0;

    // reset held for 3 cycles
    rst_nxt = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check_eq("rst_cs", 32'(bus.cs), 32'd1);
    check_eq("rst_grant", 32'(bus.grant), 32'd0);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_start", 32'(bus.spi_start), 32'd0);
    check_eq("rst_data", 32'(bus.spi_data), 32'h00);
    check_eq("rst_dc", 32'(bus.spi_dc), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    rst_nxt = 1'b0;
    step();

    // fairness: req 0 and 2 always valid with single-byte bursts
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push_burst(0, 1);
      push_burst(2, 1);
    end
    run_until_idle(400);
`ifdef SPI_ARB_FIXED_PRIO_EN
    check_eq("fair_g0", 32'(qget(gr_val, 0)), 32'd1);
    check_eq("fair_g1", 32'(qget(gr_val, 1)), 32'd1);
    check_eq("fair_g2", 32'(qget(gr_val, 2)), 32'd1);
    check_eq("fair_g3", 32'(qget(gr_val, 3)), 32'd1);
`else
    check_eq("fair_g0", 32'(qget(gr_val, 0)), 32'd1);
    check_eq("fair_g1", 32'(qget(gr_val, 1)), 32'd4);
    check_eq("fair_g2", 32'(qget(gr_val, 2)), 32'd1);
    check_eq("fair_g3", 32'(qget(gr_val, 3)), 32'd4);
`endif

    // single byte 0xAE/dc0 on req 0, shifter done 16 cycles after start
    clear_logs();
    dly_fixed = 16;
    q[0].push_back({1'b1, 1'b0, 8'hAE});
    step();
    t0 = cyc; tc = -1; tb = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if ((st_cyc.size() > 0) && (tc < 0) && bus.cs) tc = cyc;
      if ((tc >= 0) && (tb < 0) && !bus.busy) tb = cyc;
    end
    check_eq("sb_grant_t", 32'(qget(gr_cyc, 0) - t0), 32'd1);
    check_eq("sb_grant_v", 32'(qget(gr_val, 0)), 32'd1);
    check_eq("sb_csdn_t", 32'(qget(cs_dn, 0) - t0), 32'd1);
    check_eq("sb_ready_t", 32'(qget(rd_cyc, 0) - t0), 32'd3);
    check_eq("sb_start_t", 32'(qget(st_cyc, 0) - t0), 32'd4);
    check_eq("sb_start_b", 32'(qget(st_byte, 0)), 32'h0AE);
    check_eq("sb_done_t", 32'(qget(dn_cyc, 0) - t0), 32'd20);
    check_eq("sb_csup_t", 32'(tc - t0), 32'd21);
    check_eq("sb_idle_t", 32'(tb - t0), 32'd23);
    dly_fixed = 0;

    // three-byte burst on req 1
    clear_logs();
    q[1].push_back({1'b0, 1'b0, 8'h21});
    q[1].push_back({1'b0, 1'b1, 8'h00});
    q[1].push_back({1'b1, 1'b1, 8'h7F});
    run_until_idle(300);
    check_eq("bu_nstart", 32'(st_cyc.size()), 32'd3);
    check_eq("bu_b0", 32'(qget(st_byte, 0)), 32'h021);
    check_eq("bu_b1", 32'(qget(st_byte, 1)), 32'h100);
    check_eq("bu_b2", 32'(qget(st_byte, 2)), 32'h17F);
    check_eq("bu_gap1", 32'(qget(st_cyc, 1) - qget(dn_cyc, 0)), 32'd2);
    check_eq("bu_gap2", 32'(qget(st_cyc, 2) - qget(dn_cyc, 1)), 32'd2);
    check_eq("bu_csdn_n", 32'(cs_dn.size()), 32'd1);
    check_eq("bu_csup_n", 32'(cs_up.size()), 32'd1);
    check_eq("bu_csup_t", 32'(qget(cs_up, 0) - qget(dn_cyc, 2)), 32'd1);

    // owner stall in LOAD while another requester waits
    clear_logs();
    q[3].push_back({1'b0, 1'b1, 8'h11});
    q[3].push_back({1'b1, 1'b1, 8'h33});
    for (int k = 0; (k < 20) && (gr_val.size() == 0); k++) step();
    q[1].push_back({1'b1, 1'b0, 8'h44});
    for (int k = 0; (k < 50) && (st_cyc.size() == 0); k++) step();
    check_eq("st_first", 32'(st_cyc.size()), 32'd1);
    stall[3] = 1'b1;
    n0 = st_cyc.size();
    for (int k = 0; k < 50; k++) step();
    check_eq("st_nostart", 32'(st_cyc.size() - n0), 32'd0);
    check_eq("st_grant", 32'(bus.grant), 32'h8);
    check_eq("st_cs", 32'(bus.cs), 32'd0);
    stall[3] = 1'b0;
    run_until_idle(300);
    check_eq("st_b1", 32'(qget(st_byte, 1)), 32'h133);
    check_eq("st_g1", 32'(qget(gr_val, 1)), 32'h2);

    // reset while a byte is in flight
    clear_logs();
    dly_fixed = 10;
    q[1].push_back({1'b0, 1'b0, 8'h55});
    q[1].push_back({1'b1, 1'b0, 8'h66});
    for (int k = 0; (k < 50) && (st_cyc.size() == 0); k++) step();
    step();
    step();
    check_eq("rw_busy_pre", 32'(bus.busy), 32'd1);
    rst_nxt = 1'b1;
    q[1].delete();
    step();
    rst_nxt = 1'b0;
    step();
    check_eq("rw_cs", 32'(bus.cs), 32'd1);
    check_eq("rw_grant", 32'(bus.grant), 32'd0);
    check_eq("rw_busy", 32'(bus.busy), 32'd0);
    dly_fixed = 0;
    clear_logs();
    q[2].push_back({1'b1, 1'b0, 8'h5A});
    q[3].push_back({1'b1, 1'b1, 8'hA5});
    run_until_idle(200);
    check_eq("rw_regrant", 32'(qget(gr_val, 0)), 32'h4);

    // randomized traffic with random stalls and shifter delays
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        n0 = int'($urandom_range(0, 3));
        if (q[n0].size() < 6) push_burst(n0, int'($urandom_range(1, 3)));
      end
      if ($urandom_range(0, 29) == 0) begin
        n0 = int'($urandom_range(0, 3));
        stall[n0] = ~stall[n0];
      end
      step();
    end
    stall = 4'b0000;
    run_until_idle(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spi_disp_arbiter.md
# spi_disp_arbiter

Shares one SPI byte shifter (cs/scl/sda/dc display link) among four requesters, e.g. init sequencer, frame updater, button-driven command source, debug port. Grants the link per burst with round-robin fairness. Owns the active-low chip select: low for the whole burst, with programmable setup and minimum-idle gaps. Forwards each byte and its D/C flag to the shifter as a start pulse, then waits for the shifter's done pulse.

## Interface
- CS_SETUP, 2, cycles cs is held low before the first byte of a burst (0 allowed)
- CS_IDLE, 2, minimum cycles cs is held high after a burst (0 treated as 1)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  4  requester i has a byte pending
- req_data  in  32  byte of requester i at [8i+7:8i]
- req_dc  in  4  D/C flag of requester i's byte (0 command, 1 data)
- req_last  in  4  requester i's byte ends its burst
- req_ready  out  4  byte of requester i accepted this cycle
- grant  out  4  one-hot current owner, 0 when idle
- spi_start  out  1  one-cycle pulse to shifter
- spi_data  out  8  byte to shifter, stable from spi_start until spi_done
- spi_dc  out  1  D/C to shifter, stable like spi_data
- spi_done  in  1  one-cycle pulse from shifter, byte finished; never in the same cycle as spi_start
- cs  out  1  display chip select, active-low
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SETUP, LOAD, WAIT, RELEASE.
- IDLE: cs=1, grant=0. If any req_valid, pick a winner. Round-robin search order is ptr, ptr+1, … mod 4. Next state is SETUP, or LOAD if CS_SETUP=0. Registered grant and cs=0 take effect the next cycle.
- SETUP: cs=0, counts CS_SETUP cycles, then LOAD.
- LOAD: req_ready[owner] = req_valid[owner] (combinational, only in LOAD).
  - On acceptance: data, dc and last are registered; spi_start=1 next cycle; state goes to WAIT.
  - If the owner's valid is low: stay in LOAD with cs low indefinitely. The burst stays locked and other requesters are not granted.
- WAIT: spi_start is high only in the first WAIT cycle. spi_done is honoured in any WAIT cycle.
  - On spi_done: if the last flag is set, go to RELEASE; otherwise go to LOAD.
- RELEASE: cs=1, grant=0. Lasts max(CS_IDLE,1) cycles, then IDLE. ptr = owner+1 mod 4, set on entry.
- spi_done outside WAIT is ignored. req_* of non-owners are ignored.
- Reset: next cycle state=IDLE, and all outputs take their reset values:
  - cs=1
  - grant=0, req_ready=0
  - spi_start=0, spi_data=0x00, spi_dc=0
  - busy=0
  - ptr=0
- Reset mid-burst aborts the burst. The shifter shares the same reset.

## Timing
- Arbitration latency (IDLE with valid at cycle 0):
  - grant and cs=0 at cycle 1
  - req_ready at cycle 1+CS_SETUP
  - spi_start at cycle 2+CS_SETUP
- Inter-byte gap within a burst: spi_done at cycle n → LOAD at n+1 (req_ready if valid) → spi_start at n+2.
- Burst end: spi_done at cycle n → cs=1 at n+1 → IDLE at n+1+max(CS_IDLE,1) → earliest next grant the cycle after.
- cs never toggles between bytes of one burst. A grant change only happens through RELEASE.

## Configuration
- SPI_ARB_FIXED_PRIO_EN defined: fixed priority. The lowest-index valid requester always wins, and ptr is not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset held 3 cycles → cs=1, grant=0000, req_ready=0000, spi_start=0, spi_data=0x00, busy=0.
- Single byte: req_valid[0]=1, data 0xAE, dc=0, last=1 at cycle 0; shifter done at cycle 20.
  - grant=0001 and cs=0 at cycle 1
  - req_ready[0] at cycle 3
  - spi_start with spi_data=0xAE, spi_dc=0 at cycle 4
  - cs=1 at cycle 21, busy=0 at cycle 23
- Burst on req 1: bytes 0x21/dc0, 0x00/dc1, 0x7F/dc1, last on third.
  - Three spi_start pulses with matching data and dc.
  - cs continuously low from grant to the third done+1.
  - Each start comes 2 cycles after the previous done.
- Fairness: req 0 and req 2 continuously valid with single-byte bursts → grants 0,2,0,2. With SPI_ARB_FIXED_PRIO_EN → 0,0,0,0.
- Stall: req 3 owner drops valid in LOAD for 50 cycles while req_valid[1]=1 → cs stays low, no spi_start, grant stays 1000. The burst resumes when valid returns.
- Reset in WAIT of a burst → next cycle cs=1, grant=0, state IDLE. A subsequent request from req 2 is granted (ptr=0 search).
